// File: rtl/r_type_encoder_pkg.sv
// Shared types for the R-type encoder.
// reg_arith_kind_t names the ten RV32I register-arithmetic operations.
// rak_invalid and any value above rak_and are rejected by the encoder.
package r_type_encoder_pkg;

  typedef enum logic [3:0] {
    rak_invalid = 4'd0,
    rak_add     = 4'd1,
    rak_sub     = 4'd2,
    rak_sll     = 4'd3,
    rak_slt     = 4'd4,
    rak_sltu    = 4'd5,
    rak_xor     = 4'd6,
    rak_srl     = 4'd7,
    rak_sra     = 4'd8,
    rak_or      = 4'd9,
    rak_and     = 4'd10
  } reg_arith_kind_t;

endpackage

// File: rtl/r_type_encoder.sv
// r_type_encoder: turns an RV32I register-arithmetic operation into its 32-bit R-type word,
// buffers the words in a small FIFO and drains them over a valid/ready port. Each drained word
// carries a sequential instruction-memory byte address.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   clear           synchronous flush of FIFO, address counter and error state
//   in_valid/ready  operation handshake; in_kind/in_rd/in_rs1/in_rs2 describe the operation
//   out_valid/ready word handshake; out_instr is the FIFO head, out_addr its byte address
//   err_invalid     sticky: an invalid kind was accepted
//   err_count       accepted-but-rejected operations, saturating at 255
module r_type_encoder
  import r_type_encoder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_arith_kind_t   in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_invalid,
  output logic [7:0]        err_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0]   PtrOne   = PtrW'(1);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [6:0]        OpcodeOp = 7'b0110011;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic        kind_ok;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] enc_word;

  always_comb begin
    kind_ok = 1'b1;
    funct3  = 3'b000;
    funct7  = 7'b0000000;
    unique case (in_kind)
      rak_add:  funct3 = 3'b000;
      rak_sub:  funct7 = 7'b0100000;
      rak_sll:  funct3 = 3'b001;
      rak_slt:  funct3 = 3'b010;
      rak_sltu: funct3 = 3'b011;
      rak_xor:  funct3 = 3'b100;
      rak_srl:  funct3 = 3'b101;
      rak_sra: begin
        funct3 = 3'b101;
        funct7 = 7'b0100000;
      end
      rak_or:   funct3 = 3'b110;
      rak_and:  funct3 = 3'b111;
      default:  kind_ok = 1'b0;
    endcase
  end

  assign enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, OpcodeOp};

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [31:0]       mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_invalid_q, err_invalid_d;
  logic [7:0]        err_count_q, err_count_d;

  logic accept;
  logic push;
  logic reject;
  logic pop;
  logic full;
  logic [31:0] head_next;

  // DEPTH is a power of two, so the occupancy MSB alone marks "full".
  assign full      = count_q[CntW-1];
  assign out_valid = (count_q != '0);
  assign in_ready  = !rst && !full && !clear;

  assign accept = in_valid && in_ready;
  assign push   = accept && kind_ok;
  assign reject = accept && !kind_ok;
  assign pop    = out_valid && out_ready && !clear;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    addr_d        = addr_q;
    err_invalid_d = err_invalid_q;
    err_count_d   = err_count_q;

    if (clear) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      addr_d        = BaseAddr;
      err_invalid_d = 1'b0;
      err_count_d   = 8'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        addr_d   = addr_q + AddrStep;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      if (reject) begin
        err_invalid_d = 1'b1;
        if (err_count_q != 8'hff) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    end
  end

  // The next head is the word being written this cycle when it lands in the slot the read
  // pointer moves to (FIFO was empty, or held one entry that is popped alongside the push).
  always_comb begin
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_next = enc_word;
    end else begin
      head_next = mem[rd_ptr_d];
    end
  end

  // out_instr only tracks the head while something is buffered; otherwise it holds.
  assign out_instr_d = (count_d != '0) ? head_next : out_instr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_instr_q   <= 32'd0;
      addr_q        <= BaseAddr;
      err_invalid_q <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_instr_q   <= out_instr_d;
      addr_q        <= addr_d;
      err_invalid_q <= err_invalid_d;
      err_count_q   <= err_count_d;
    end
  end

  assign out_instr   = out_instr_q;
  assign out_addr    = addr_q;
  assign err_invalid = err_invalid_q;
  assign err_count   = err_count_q;

endmodule
